// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: push-button mode sequencer (OFF/ALL_ON/BLINK/CHASE) for O1..O5 plus press-ack LED.
// Define LED_SEQ_DEBOUNCE_EN to insert a millisecond debounce filter on the synchronised button.
module led_seq_ctrl #(
   parameter int F_CLK_HZ       = 25_000_000,
   parameter int DEBOUNCE_MS    = 20,
   parameter int STEP_MS        = 250,
   parameter int ACK_MS         = 100,
   parameter bit LED_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       I1,
   output logic       led,
   output logic       O1,
   output logic       O2,
   output logic       O3,
   output logic       O4,
   output logic       O5,
   output logic [1:0] mode
);
   localparam int CYC = F_CLK_HZ / 1000;
   localparam int PW = CYC > 1 ? $clog2(CYC) : 1;
   localparam int SW = STEP_MS > 1 ? $clog2(STEP_MS) : 1;
   localparam int AW = $clog2(ACK_MS + 1);
   localparam logic [PW-1:0] PRE_MAX = PW'(CYC - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_MS - 1);
   localparam logic [AW-1:0] ACK_INIT = AW'(ACK_MS);

   typedef enum logic [1:0] {OFF, ALL_ON, BLINK, CHASE} state_t;

   state_t state, state_nxt;
   logic [PW-1:0] pre;
   logic ms_tick;
   logic [1:0] sync;
   logic i_sync, clean, clean_q, press;
   logic [SW-1:0] step_cnt;
   logic stepping, step, phase;
   logic [2:0] idx;
   logic [AW-1:0] ack;
   logic [4:0] o, o_nxt;

   if (CYC < 1 || CYC * 1000 != F_CLK_HZ || DEBOUNCE_MS < 1 || STEP_MS < 1 || ACK_MS < 1) begin : g_bad_param
      $error("led_seq_ctrl: invalid parameter set");
   end

   assign ms_tick = pre == PRE_MAX;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre  <= '0;
         sync <= '0;
      end else begin
         pre  <= ms_tick ? '0 : pre + 1'b1;
         sync <= {sync[0], I1};
      end
   end

   assign i_sync = sync[1];

`ifdef LED_SEQ_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_MS + 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_MS);
   logic [DW-1:0] db_cnt;

   // Any sample matching the clean level restarts the qualification window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt <= '0;
         clean  <= 1'b0;
      end else if (i_sync == clean) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
         clean  <= i_sync;
         db_cnt <= '0;
      end else if (ms_tick) begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   assign clean = i_sync;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clean_q <= 1'b0;
      else        clean_q <= clean;
   end

   assign press = clean & ~clean_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= OFF;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = press ? state_t'(state + 2'd1) : state;
   end

   assign stepping = state == BLINK || state == CHASE;
   assign step = ms_tick && stepping && step_cnt == STEP_LAST;

   // A press reinitialises the step machinery, so a coincident step is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt <= '0;
         phase    <= 1'b0;
         idx      <= '0;
      end else if (press) begin
         step_cnt <= '0;
         phase    <= 1'b1;
         idx      <= '0;
      end else if (!stepping) begin
         step_cnt <= '0;
      end else if (ms_tick) begin
         step_cnt <= step ? '0 : step_cnt + 1'b1;
         phase    <= step ? ~phase : phase;
         idx      <= !step ? idx : idx == 3'd4 ? 3'd0 : idx + 3'd1;
      end
   end

   always_comb begin
      o_nxt = state == OFF    ? 5'b00000 :
              state == ALL_ON ? 5'b11111 :
              state == BLINK  ? {5{phase}} : 5'b00001 << idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o   <= '0;
         ack <= '0;
      end else begin
         o   <= o_nxt;
         ack <= press ? ACK_INIT : (ms_tick && ack != '0) ? ack - 1'b1 : ack;
      end
   end

   assign {O5, O4, O3, O2, O1} = o;
   assign mode = state;
   assign led = (ack != '0) ^ LED_ACTIVE_LOW;
endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Mode sequencer for the board's five indicator outputs (O1..O5) and status LED. A push-button on I1 steps the block through four display modes: OFF, ALL_ON, BLINK and CHASE. The block owns the millisecond timebase, input synchronisation/debounce, mode FSM and step timing. It replaces direct I1-to-output wiring at the top level.

Parameters:
F_CLK_HZ, 25_000_000, input clock frequency in Hz; must be a multiple of 1000.
DEBOUNCE_MS, 20, ms the synchronised I1 must differ from the clean level before the clean level updates (≥1).
STEP_MS, 250, ms per BLINK phase toggle and per CHASE position advance (≥1).
ACK_MS, 100, ms the status LED stays active after each accepted press (≥1).
LED_ACTIVE_LOW, 0, 0 = led active-high, 1 = led active-low; O1..O5 are always active-high.

Ports:
clk  in  1  system clock, F_CLK_HZ
rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk
I1  in  1  push-button, active-high, asynchronous to clk
led  out  1  press-acknowledge LED, polarity per LED_ACTIVE_LOW
O1  out  1  indicator 1
O2  out  1  indicator 2
O3  out  1  indicator 3
O4  out  1  indicator 4
O5  out  1  indicator 5
mode  out  2  current mode: 0 OFF, 1 ALL_ON, 2 BLINK, 3 CHASE

Behaviour:
- Reset values: all internal registers are 0; mode=0; O1..O5=0; led = LED_ACTIVE_LOW (inactive level).
- Timebase: prescaler counts 0..F_CLK_HZ/1000-1 and wraps. ms_tick is a 1-cycle pulse on the wrap cycle. Width is $clog2 of the terminal count, minimum 1.
- Synchroniser: 2-flop chain on I1 produces i_sync.
- Press event: a 1-cycle pulse on each rising edge of the clean level (the debounced level, or i_sync when debounce is compiled out). A falling edge never generates a press.
- Mode FSM:
  - Transitions on press: OFF -> ALL_ON -> BLINK -> CHASE -> OFF (wraps).
  - Without a press the FSM holds its mode.
  - mode is the registered state and changes on the clock edge that samples the press.
- Step timer:
  - ms counter 0..STEP_MS-1, advanced on ms_tick. The step event fires on the tick where the counter reaches STEP_MS-1; the counter then wraps to 0.
  - Counts only in BLINK and CHASE; held at 0 in OFF and ALL_ON.
- BLINK: phase bit toggles on each step event. Phase starts at 1 on mode entry, so the outputs light immediately.
- CHASE: index 0..4 advances on each step event and wraps 4 -> 0. Index starts at 0 on entry.
- Output decode, registered (one cycle after mode/phase/index):
  - OFF: all O = 0.
  - ALL_ON: all O = 1.
  - BLINK: all O = phase.
  - CHASE: one-hot, with O(index+1)=1 (O1 when index=0).
- Ack timer:
  - Each press loads ACK_MS into the ack counter; each ms_tick decrements it while it is nonzero.
  - led_on = (ack counter != 0); led = led_on XOR LED_ACTIVE_LOW.
- Simultaneous events:
  - Press in the same cycle as a step event: the mode change wins. Step counter, phase and index are reinitialised for the new mode; the step is discarded.
  - Press while the ack timer is running: the timer reloads to ACK_MS.
- Reset mid-operation: every output returns to its reset value asynchronously. The first press after release selects ALL_ON.

Optional Feature:
Macro LED_SEQ_DEBOUNCE_EN.
- Defined:
  - A debounce counter advances on ms_tick while i_sync != clean level and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_MS, the clean level takes i_sync and the counter clears.
  - Pulses shorter than DEBOUNCE_MS ms on I1 are ignored, on both press and release.
- Not defined:
  - Clean level = i_sync; no debounce counter is instantiated.
  - The press pulse occurs on the cycle after i_sync rises.
  - Mode updates at the 3rd rising clk edge after I1 rises; outputs update on the 4th.

Test Plan:
Bench parameters for all scenarios: F_CLK_HZ=10_000 (10 cycles/ms), DEBOUNCE_MS=4, STEP_MS=3, ACK_MS=2, LED_ACTIVE_LOW=0.
1. Reset: hold rst_n=0 with I1 toggling -> mode=0, O1..O5=0, led=0 throughout. Release, with I1=0 for 100 cycles -> no change.
2. Four clean presses (I1 high 80 cycles, low 80 cycles) -> mode goes 1,2,3,0. led is high for 20 cycles (±10) after each press. ALL_ON drives O=5'b11111.
3. BLINK entry: O=11111 immediately, then toggles every 30 cycles (11111, 00000, ...). After 5 toggles, press -> CHASE with O1=1, advancing O1→O2→…→O5→O1 every 30 cycles.
4. With LED_SEQ_DEBOUNCE_EN defined: a 25-cycle (<4 ms) I1 pulse -> no mode change, led stays 0. A 60-cycle pulse -> exactly one mode advance. Chatter of 5 toggles within 20 cycles, then a steady high -> exactly one advance.
5. Press aligned to the CHASE step-event cycle at index=4 -> mode=0, all O=0, no extra advance. Next press -> ALL_ON.
6. Assert rst_n mid-CHASE with the ack timer running -> O=0, led=0, mode=0 asynchronously, with no clk edge required. Also rerun scenario 2 with LED_ACTIVE_LOW=1 -> led idles 1 and pulses 0.
